// File: rtl/quant_block_ctrl.sv
// rtl/quant_block_ctrl.sv - column-beat sequencer for the 8x8 block quantiser
//
// Walks one 8x8 DCT block through the quantiser as 8 column beats, tags each
// accepted beat through a Q_LAT-deep pipe so results carry column/last flags,
// and meters beats against downstream credits (the quantiser cannot stall).
//
// Optional feature macro: QUANT_BANK_EN (adds q_sel/q_bank table bank select).
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-low reset
//   blk_start                   start a block (sampled in IDLE only)
//   abort                       synchronous abort of the current block
//   in_valid / in_ready         DCT column beat handshake
//   q_start, q_col              quantiser enable and table column (combinational)
//   out_valid, out_col, out_last  delayed result tag
//   cred_ret                    downstream freed one column slot
//   busy, blk_done, blk_count   status, done pulse, completed-block counter
//   cred_err                    sticky credit overflow flag
//   q_sel / q_bank              (QUANT_BANK_EN) bank request / bank held per block

module quant_block_ctrl #(
    parameter int Q_LAT   = 1,
    parameter int CREDITS = 4,
    parameter int BLKW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            blk_start,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            q_start,
    output logic [2:0]      q_col,
    output logic            out_valid,
    output logic [2:0]      out_col,
    output logic            out_last,
    input  logic            cred_ret,
    output logic            busy,
    output logic            blk_done,
    output logic [BLKW-1:0] blk_count,
    output logic            cred_err
`ifdef QUANT_BANK_EN
    ,
    input  logic [1:0]      q_sel,
    output logic [1:0]      q_bank
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t                  state_q, state_d;
    logic [2:0]              col_q, col_d;
    logic [3:0]              cred_q, cred_d;
    logic [Q_LAT-1:0]        vld_q, vld_d;
    logic [Q_LAT-1:0][2:0]   tcol_q, tcol_d;
    logic [BLKW-1:0]         cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    accept;
`ifdef QUANT_BANK_EN
    logic [1:0]              bank_q, bank_d;
`endif

    always_comb begin
        // abort wins over accept, so the handshake is withdrawn in that cycle
        in_ready = (state_q == RUN) && (cred_q != 4'd0) && !abort;
        accept   = in_valid && in_ready;
        q_start  = accept;
        q_col    = accept ? col_q : 3'd0;

        state_d = state_q;
        col_d   = col_q;
        cred_d  = cred_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef QUANT_BANK_EN
        bank_d  = bank_q;
`endif

        // Tag pipe: stage 0 takes the accepted beat, last stage is the output
        vld_d     = '0;
        tcol_d    = '0;
        vld_d[0]  = accept;
        tcol_d[0] = q_col;
        for (int i = 1; i < Q_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            tcol_d[i] = tcol_q[i-1];
        end

        // A simultaneous accept and return cancel out, so no overflow there
        case ({accept, cred_ret})
            2'b10: cred_d = cred_q - 4'd1;
            2'b01: begin
                if (cred_q == CRED_MAX) err_d = 1'b1;
                else                    cred_d = cred_q + 4'd1;
            end
            default: cred_d = cred_q;
        endcase

        case (state_q)
            IDLE: begin
                if (blk_start) begin
                    state_d = RUN;
                    col_d   = 3'd0;
`ifdef QUANT_BANK_EN
                    bank_d  = q_sel;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    col_d = col_q + 3'd1;
                    if (col_q == 3'd7) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the last tag sits in the output stage, so
                // DONE follows the final out_valid cycle directly.
                if (vld_d == '0) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = cnt_q + BLKW'(1);
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            col_d   = 3'd0;
            cred_d  = CRED_MAX;
            vld_d   = '0;
            tcol_d  = '0;
            cnt_d   = cnt_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= 3'd0;
            cred_q  <= CRED_MAX;
            vld_q   <= '0;
            tcol_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef QUANT_BANK_EN
            bank_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cred_q  <= cred_d;
            vld_q   <= vld_d;
            tcol_q  <= tcol_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef QUANT_BANK_EN
            bank_q  <= bank_d;
`endif
        end
    end

    assign out_valid = vld_q[Q_LAT-1];
    assign out_col   = vld_q[Q_LAT-1] ? tcol_q[Q_LAT-1] : 3'd0;
    assign out_last  = vld_q[Q_LAT-1] && (tcol_q[Q_LAT-1] == 3'd7);
    assign busy      = (state_q != IDLE);
    assign blk_done  = (state_q == DONE) && !abort;
    assign blk_count = cnt_q;
    assign cred_err  = err_q;
`ifdef QUANT_BANK_EN
    assign q_bank    = bank_q;
`endif

endmodule

// File: tb/tb_quant_block_ctrl.sv
// tb/tb_quant_block_ctrl.sv - self-checking bench for quant_block_ctrl
module tb_quant_block_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, blk_start, abort, in_valid, cred_ret;

    logic        in_ready1, q_start1, out_valid1, out_last1, busy1, blk_done1, cred_err1;
    logic [2:0]  q_col1, out_col1;
    logic [15:0] blk_count1;
    logic        in_ready3, q_start3, out_valid3, out_last3, busy3, blk_done3, cred_err3;
    logic [2:0]  q_col3, out_col3;
    logic [15:0] blk_count3;
`ifdef QUANT_BANK_EN
    logic [1:0]  q_sel, q_bank1, q_bank3;
`endif

    quant_block_ctrl #(.Q_LAT(1), .CREDITS(4), .BLKW(16)) u_dut1 (
        .clk(clk), .reset(reset), .blk_start(blk_start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready1), .q_start(q_start1), .q_col(q_col1),
        .out_valid(out_valid1), .out_col(out_col1), .out_last(out_last1),
        .cred_ret(cred_ret), .busy(busy1), .blk_done(blk_done1),
        .blk_count(blk_count1), .cred_err(cred_err1)
`ifdef QUANT_BANK_EN
        , .q_sel(q_sel), .q_bank(q_bank1)
`endif
    );

    quant_block_ctrl #(.Q_LAT(3), .CREDITS(4), .BLKW(16)) u_dut3 (
        .clk(clk), .reset(reset), .blk_start(blk_start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready3), .q_start(q_start3), .q_col(q_col3),
        .out_valid(out_valid3), .out_col(out_col3), .out_last(out_last3),
        .cred_ret(cred_ret), .busy(busy3), .blk_done(blk_done3),
        .blk_count(blk_count3), .cred_err(cred_err3)
`ifdef QUANT_BANK_EN
        , .q_sel(q_sel), .q_bank(q_bank3)
`endif
    );

    // Monitored instance select: 0 -> Q_LAT=1 instance, 1 -> Q_LAT=3 instance
    logic       sel3 = 1'b0;
    logic       m_q_start, m_out_valid, m_out_last, m_blk_done, m_in_ready;
    logic [2:0] m_q_col, m_out_col;
    int         m_lat;
    assign m_q_start   = sel3 ? q_start3   : q_start1;
    assign m_q_col     = sel3 ? q_col3     : q_col1;
    assign m_out_valid = sel3 ? out_valid3 : out_valid1;
    assign m_out_col   = sel3 ? out_col3   : out_col1;
    assign m_out_last  = sel3 ? out_last3  : out_last1;
    assign m_blk_done  = sel3 ? blk_done3  : blk_done1;
    assign m_in_ready  = sel3 ? in_ready3  : in_ready1;
    assign m_lat       = sel3 ? 3 : 1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] col;
        int         cyc;
    } tag_t;

    logic [2:0] exp_col_q[$];
    tag_t       tag_q[$];
    int         acc_cnt = 0;
    int         first_acc = 0;
    int         last_acc = 0;
    logic       mon_en = 1'b0;
    logic [2:0] mon_e;
    tag_t       mon_t;

    // Scoreboard: expected q_col values are queued by the tests; every accept
    // turns into a pending tag that must come out Q_LAT cycles later.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_q_start === 1'b1) begin
                acc_cnt++;
                if (acc_cnt == 1) first_acc = cyc;
                last_acc = cyc;
                total++;
                if (exp_col_q.size() == 0) begin
                    bad++;
                    $display("FAIL q_col_unexpected got=%0d want=none", m_q_col);
                end else begin
                    mon_e = exp_col_q.pop_front();
                    if (m_q_col !== mon_e) begin
                        bad++;
                        $display("FAIL q_col got=%0d want=%0d", m_q_col, mon_e);
                    end
                    tag_q.push_back('{col: mon_e, cyc: cyc});
                end
            end
            if (m_out_valid === 1'b1) begin
                total++;
                if (tag_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected got_col=%0d want=none", m_out_col);
                end else begin
                    mon_t = tag_q.pop_front();
                    if (m_out_col !== mon_t.col) begin
                        bad++;
                        $display("FAIL out_col got=%0d want=%0d", m_out_col, mon_t.col);
                    end
                    total++;
                    if (m_out_last !== (mon_t.col == 3'd7)) begin
                        bad++;
                        $display("FAIL out_last got=%0b want=%0b", m_out_last, mon_t.col == 3'd7);
                    end
                    total++;
                    if (cyc - mon_t.cyc !== m_lat) begin
                        bad++;
                        $display("FAIL out_latency got=%0d want=%0d", cyc - mon_t.cyc, m_lat);
                    end
                end
            end else begin
                total++;
                if (m_out_last !== 1'b0) begin
                    bad++;
                    $display("FAIL out_last_idle got=%0b want=0", m_out_last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        blk_start = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        cred_ret  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        step();
        tag_q.delete();
        exp_col_q.delete();
        reset = 1'b1;
        step();
    endtask

    task automatic push_cols(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) exp_col_q.push_back(3'(c));
    endtask

    task automatic do_abort();
        abort = 1'b1;
        in_valid = 1'b0;
        cred_ret = 1'b0;
        step();
        abort = 1'b0;
        tag_q.delete();
        step();
    endtask

    // Runs a block with in_valid held high and downstream returning a credit
    // in every cycle that shows a result.
    task automatic run_block(input int budget, output bit done_seen, output int done_cyc);
        done_seen = 1'b0;
        done_cyc  = 0;
        blk_start = 1'b1;
        in_valid  = 1'b1;
        cred_ret  = 1'b0;
        for (int i = 0; i < budget && !done_seen; i++) begin
            step();
            blk_start = 1'b0;
            cred_ret  = m_out_valid;
            if (m_blk_done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
        in_valid = 1'b0;
        cred_ret = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        sample();
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready1); end
        total++; if (q_start1 !== 1'b0) begin bad++; $display("FAIL rst_q_start got=%b want=0", q_start1); end
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy1); end
        total++; if (blk_done1 !== 1'b0) begin bad++; $display("FAIL rst_blk_done got=%b want=0", blk_done1); end
        total++; if (blk_count1 !== 16'd0) begin bad++; $display("FAIL rst_blk_count got=%0d want=0", blk_count1); end
        total++; if (cred_err1 !== 1'b0) begin bad++; $display("FAIL rst_cred_err got=%b want=0", cred_err1); end
`ifdef QUANT_BANK_EN
        total++; if (q_bank1 !== 2'd0) begin bad++; $display("FAIL rst_q_bank got=%0d want=0", q_bank1); end
`endif
        mon_en = 1'b1;
        reset = 1'b1;
        step();
    endtask

    task automatic test_full_block();
        bit done_seen;
        int done_cyc;
        sel3 = 1'b0;
        do_reset();
        push_cols(0, 7);
        acc_cnt = 0;
        run_block(40, done_seen, done_cyc);
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL full_done_seen got=%b want=1", done_seen); end
        total++; if (acc_cnt !== 8) begin bad++; $display("FAIL full_accepts got=%0d want=8", acc_cnt); end
        total++; if (last_acc - first_acc !== 7) begin bad++; $display("FAIL full_consecutive span=%0d want=7", last_acc - first_acc); end
        total++; if (done_cyc - last_acc !== 2) begin bad++; $display("FAIL full_done_timing got=%0d want=2", done_cyc - last_acc); end
        total++; if (exp_col_q.size() !== 0) begin bad++; $display("FAIL full_cols_left got=%0d want=0", exp_col_q.size()); end
        step();
        sample();
        total++; if (blk_count1 !== 16'd1) begin bad++; $display("FAIL full_blk_count got=%0d want=1", blk_count1); end
        total++; if (blk_done1 !== 1'b0) begin bad++; $display("FAIL full_done_pulse got=%b want=0", blk_done1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL full_busy got=%b want=0", busy1); end
        total++; if (tag_q.size() !== 0) begin bad++; $display("FAIL full_tags_left got=%0d want=0", tag_q.size()); end
    endtask

    task automatic test_credit_stall();
        sel3 = 1'b0;
        do_reset();
        push_cols(0, 4);
        acc_cnt = 0;
        blk_start = 1'b1;
        in_valid = 1'b1;
        step();
        blk_start = 1'b0;
        repeat (9) step();
        total++; if (acc_cnt !== 4) begin bad++; $display("FAIL stall_accepts got=%0d want=4", acc_cnt); end
        sample();
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready1); end
        step();
        cred_ret = 1'b1;
        step();
        cred_ret = 1'b0;
        repeat (5) step();
        total++; if (acc_cnt !== 5) begin bad++; $display("FAIL stall_one_more got=%0d want=5", acc_cnt); end
        sample();
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL stall_in_ready2 got=%b want=0", in_ready1); end
        step();
        do_abort();
    endtask

    task automatic test_cred_simul();
        sel3 = 1'b0;
        do_reset();
        push_cols(0, 4);
        acc_cnt = 0;
        blk_start = 1'b1;
        in_valid = 1'b1;
        step();
        blk_start = 1'b0;
        step();
        step();
        step();
        cred_ret = 1'b1;
        sample();
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL simul_ready_c1 got=%b want=1", in_ready1); end
        step();
        cred_ret = 1'b0;
        in_valid = 1'b0;
        sample();
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL simul_ready_after got=%b want=1", in_ready1); end
        total++; if (acc_cnt !== 4) begin bad++; $display("FAIL simul_accepts got=%0d want=4", acc_cnt); end
        step();
        in_valid = 1'b1;
        repeat (5) step();
        total++; if (acc_cnt !== 5) begin bad++; $display("FAIL simul_credit_one got=%0d want=5", acc_cnt); end
        total++; if (cred_err1 !== 1'b0) begin bad++; $display("FAIL simul_cred_err got=%b want=0", cred_err1); end
        do_abort();
    endtask

    task automatic test_cred_overflow();
        sel3 = 1'b0;
        do_reset();
        cred_ret = 1'b1;
        step();
        cred_ret = 1'b0;
        sample();
        total++; if (cred_err1 !== 1'b1) begin bad++; $display("FAIL ovf_cred_err got=%b want=1", cred_err1); end
        step();
        push_cols(0, 3);
        acc_cnt = 0;
        blk_start = 1'b1;
        in_valid = 1'b1;
        step();
        blk_start = 1'b0;
        repeat (9) step();
        total++; if (acc_cnt !== 4) begin bad++; $display("FAIL ovf_credits got=%0d want=4", acc_cnt); end
        do_abort();
        sample();
        total++; if (cred_err1 !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", cred_err1); end
        step();
    endtask

    task automatic test_abort();
        bit done_seen;
        int done_cyc;
        bit saw_done;
        sel3 = 1'b1;
        do_reset();
        push_cols(0, 3);
        acc_cnt = 0;
        blk_start = 1'b1;
        in_valid = 1'b1;
        step();
        blk_start = 1'b0;
        step();
        step();
        step();
        step();
        abort = 1'b1;
        in_valid = 1'b0;
        step();
        abort = 1'b0;
        tag_q.delete();
        sample();
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid3); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy3); end
        total++; if (acc_cnt !== 4) begin bad++; $display("FAIL abort_accepts got=%0d want=4", acc_cnt); end
        saw_done = (blk_done3 === 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            sample();
            if (blk_done3 === 1'b1) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
        total++; if (blk_count3 !== 16'd0) begin bad++; $display("FAIL abort_blk_count got=%0d want=0", blk_count3); end
        step();
        push_cols(0, 7);
        acc_cnt = 0;
        run_block(60, done_seen, done_cyc);
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL restart_done got=%b want=1", done_seen); end
        total++; if (last_acc - first_acc !== 7) begin bad++; $display("FAIL restart_span got=%0d want=7", last_acc - first_acc); end
        total++; if (done_cyc - last_acc !== 4) begin bad++; $display("FAIL restart_done_timing got=%0d want=4", done_cyc - last_acc); end
        step();
        sample();
        total++; if (blk_count3 !== 16'd1) begin bad++; $display("FAIL restart_blk_count got=%0d want=1", blk_count3); end
        step();
    endtask

    task automatic test_reset_drain();
        sel3 = 1'b1;
        push_cols(0, 7);
        acc_cnt = 0;
        blk_start = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && acc_cnt < 8; i++) begin
            step();
            blk_start = 1'b0;
            cred_ret = m_out_valid;
        end
        total++; if (acc_cnt !== 8) begin bad++; $display("FAIL drain_reach got=%0d want=8", acc_cnt); end
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b want=1", busy3); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy3); end
        total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid3); end
        total++; if (out_last3 !== 1'b0) begin bad++; $display("FAIL rstmid_out_last got=%b want=0", out_last3); end
        total++; if (out_col3 !== 3'd0) begin bad++; $display("FAIL rstmid_out_col got=%0d want=0", out_col3); end
        total++; if (in_ready3 !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready got=%b want=0", in_ready3); end
        total++; if (q_start3 !== 1'b0) begin bad++; $display("FAIL rstmid_q_start got=%b want=0", q_start3); end
        total++; if (blk_count3 !== 16'd0) begin bad++; $display("FAIL rstmid_blk_count got=%0d want=0", blk_count3); end
        total++; if (blk_done3 !== 1'b0) begin bad++; $display("FAIL rstmid_blk_done got=%b want=0", blk_done3); end
        idle_inputs();
        tag_q.delete();
        exp_col_q.delete();
        step();
        step();
        reset = 1'b1;
        step();
        push_cols(0, 0);
        acc_cnt = 0;
        blk_start = 1'b1;
        step();
        blk_start = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        total++; if (acc_cnt !== 1) begin bad++; $display("FAIL rstmid_restart got=%0d want=1", acc_cnt); end
        do_abort();
    endtask

`ifdef QUANT_BANK_EN
    task automatic test_bank();
        bit done_seen;
        int done_cyc;
        sel3 = 1'b0;
        do_reset();
        q_sel = 2'd2;
        push_cols(0, 7);
        acc_cnt = 0;
        blk_start = 1'b1;
        in_valid = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            step();
            blk_start = 1'b0;
            cred_ret = m_out_valid;
            if (i == 2) q_sel = 2'd1;
            total++;
            if (q_bank1 !== 2'd2) begin bad++; $display("FAIL bank_hold got=%0d want=2", q_bank1); end
            if (blk_done1 === 1'b1) done_seen = 1'b1;
        end
        in_valid = 1'b0;
        cred_ret = 1'b0;
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL bank_done got=%b want=1", done_seen); end
        step();
        push_cols(0, 7);
        run_block(40, done_seen, done_cyc);
        total++; if (q_bank1 !== 2'd1) begin bad++; $display("FAIL bank_next got=%0d want=1", q_bank1); end
        step();
    endtask
`endif

    initial begin
`ifdef QUANT_BANK_EN
        q_sel = 2'd0;
`endif
        test_reset();
        test_full_block();
        test_credit_stall();
        test_cred_simul();
        test_cred_overflow();
        test_abort();
        test_reset_drain();
`ifdef QUANT_BANK_EN
        test_bank();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
